// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
//   Drives a 4-LED bank with one of four step patterns. A prescaler sets the
//   step rate. A PWM stage sets the brightness. A one-cycle key pulse moves
//   to the next mode.
//
// Ports
//   clk         system clock (50 MHz board clock)
//   rst_n       synchronous reset, active low
//   enable      1 = prescaler and pattern advance; 0 = both freeze (PWM runs on)
//   mode_next   single-cycle pulse, selects the next mode (3 wraps to 0)
//   brightness  PWM duty level; 0 = off, all-ones = fully on
//   led         registered LED drive, 1 = lit
//   mode        current mode (0 RUN, 1 BLINK, 2 COUNT, 3 BOUNCE)
//   tick        single-cycle pulse on each pattern step
module led_pattern_ctrl #(
  parameter int TICK_CYCLES = 12500000,
  parameter int PWM_BITS    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                mode_next,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [3:0]          led,
  output logic [1:0]          mode,
  output logic                tick
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] LAST = PW'(TICK_CYCLES - 1);

  localparam logic [1:0] MODE_RUN    = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_COUNT  = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  // r_dir: 0 = moving left (toward bit 3), 1 = moving right
  logic [PW-1:0]       r_presc;
  logic [PWM_BITS-1:0] r_pwm;
  logic [1:0]          r_mode;
  logic [3:0]          r_pat;
  logic                r_dir;
  logic                r_tick;
  logic [3:0]          r_led;

  logic       w_wrap;
  logic       w_on;
  logic [1:0] w_next_mode;
  logic [3:0] w_init_pat;
  logic [3:0] w_step_pat;
  logic       w_step_dir;

  assign w_wrap      = enable && (r_presc == LAST);
  assign w_on        = (brightness == '1) || (r_pwm < brightness);
  assign w_next_mode = r_mode + 2'd1;

  // Pattern loaded when entering a mode
  always_comb begin
    w_init_pat = 4'b0001;
    case (w_next_mode)
      MODE_RUN:    w_init_pat = 4'b0001;
      MODE_BLINK:  w_init_pat = 4'b1111;
      MODE_COUNT:  w_init_pat = 4'b0000;
      MODE_BOUNCE: w_init_pat = 4'b0001;
      default:     w_init_pat = 4'b0001;
    endcase
  end

  // Next pattern on a step
  always_comb begin
    w_step_pat = r_pat;
    w_step_dir = r_dir;
    case (r_mode)
      MODE_RUN:   w_step_pat = {r_pat[2:0], r_pat[3]};
      MODE_BLINK: w_step_pat = ~r_pat;
      MODE_COUNT: w_step_pat = r_pat + 4'd1;
      MODE_BOUNCE: begin
        w_step_pat = r_dir ? (r_pat >> 1) : (r_pat << 1);
        // Turn around at the end LEDs so they are shown only once per pass
        if (w_step_pat == 4'b1000)      w_step_dir = 1'b1;
        else if (w_step_pat == 4'b0001) w_step_dir = 1'b0;
      end
      default: w_step_pat = r_pat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_pwm   <= '0;
      r_mode  <= MODE_RUN;
      r_pat   <= 4'b0001;
      r_dir   <= 1'b0;
      r_tick  <= 1'b0;
      r_led   <= 4'b0000;
    end else begin
      r_pwm <= r_pwm + PWM_BITS'(1);
      r_led <= w_on ? r_pat : 4'b0000;
      // A mode change beats a coincident step. It restarts the step period.
      if (mode_next) begin
        r_mode  <= w_next_mode;
        r_presc <= '0;
        r_pat   <= w_init_pat;
        r_dir   <= 1'b0;
        r_tick  <= 1'b0;
      end else if (enable) begin
        r_tick  <= w_wrap;
        r_presc <= w_wrap ? '0 : r_presc + PW'(1);
        if (w_wrap) begin
          r_pat <= w_step_pat;
          r_dir <= w_step_dir;
        end
      end else begin
        r_tick <= 1'b0;
      end
    end
  end

  assign led  = r_led;
  assign mode = r_mode;
  assign tick = r_tick;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

  localparam int TC = 4;

  logic       clk = 1'b0;
  logic       rst_n, enable, mode_next;
  logic [3:0] brightness;
  logic [3:0] led;
  logic [1:0] mode;
  logic       tick;

  led_pattern_ctrl #(.TICK_CYCLES(TC), .PWM_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode_next(mode_next),
    .brightness(brightness), .led(led), .mode(mode), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, en, mn;
    logic [3:0] br;
    logic [3:0] led;
    logic [1:0] mode;
    logic       tick;
  } vec_t;

  typedef struct {
    logic [3:0] led;
    logic [1:0] mode;
    logic       tick;
  } exp_t;

  vec_t tbl[11];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model: the pattern is a step index into a fixed sequence per mode
  logic [1:0] m_mode;
  int         m_idx, m_presc, m_pwm;
  logic       m_tick;
  logic [3:0] m_led;

  function automatic logic [3:0] mpat(input logic [1:0] md, input int idx);
    logic [3:0] one;
    one = 4'b0001;
    case (md)
      2'd0:    return one << (idx % 4);
      2'd1:    return (idx % 2 == 0) ? 4'hF : 4'h0;
      2'd2:    return 4'(idx % 16);
      default: begin
        case (idx % 6)
          0: return 4'b0001;
          1: return 4'b0010;
          2: return 4'b0100;
          3: return 4'b1000;
          4: return 4'b0100;
          default: return 4'b0010;
        endcase
      end
    endcase
  endfunction

  task automatic model_step(input logic r, e, m, input logic [3:0] b);
    logic on;
    if (!r) begin
      m_mode = 0; m_idx = 0; m_presc = 0; m_tick = 0; m_pwm = 0; m_led = 0;
    end else begin
      on    = (b == 4'hF) || (m_pwm < int'(b));
      m_led = on ? mpat(m_mode, m_idx) : 4'h0;
      m_pwm = (m_pwm + 1) % 16;
      if (m) begin
        m_mode = m_mode + 2'd1; m_idx = 0; m_presc = 0; m_tick = 0;
      end else if (e) begin
        m_tick  = (m_presc == TC - 1);
        if (m_tick) m_idx = (m_idx + 1) % 48;
        m_presc = m_tick ? 0 : m_presc + 1;
      end else begin
        m_tick = 0;
      end
    end
  endtask

  task automatic check();
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard: queue empty at vector %0d", n_vec);
    end else begin
      e = sb.pop_front();
      if (led !== e.led || mode !== e.mode || tick !== e.tick) begin
        n_miss++;
        $display("FAIL vec %0d: got led=%b mode=%0d tick=%b, want led=%b mode=%0d tick=%b",
                 n_vec, led, mode, tick, e.led, e.mode, e.tick);
      end
    end
  endtask

  // Called at a negedge: drive, clock, queue the expectation, compare at next negedge
  task automatic apply(input logic r, e, m, input logic [3:0] b,
                       input bit use_tbl, input exp_t te);
    exp_t x;
    rst_n = r; enable = e; mode_next = m; brightness = b;
    @(posedge clk);
    model_step(r, e, m, b);
    x.led = m_led; x.mode = m_mode; x.tick = m_tick;
    sb.push_back(use_tbl ? te : x);
    @(negedge clk);
    check();
  endtask

  task automatic step(input logic r, e, m, input logic [3:0] b);
    exp_t d;
    d.led = 0; d.mode = 0; d.tick = 0;
    apply(r, e, m, b, 1'b0, d);
  endtask

  task automatic run(input int n, input logic e, input logic [3:0] b);
    for (int i = 0; i < n; i++) step(1, e, 0, b);
  endtask

  task automatic sync_fail(input string what);
    n_vec++;
    n_miss++;
    $display("FAIL sync %s: model state not reached within bound", what);
  endtask

  function automatic vec_t mk(input logic r, e, m, input logic [3:0] b,
                              input logic [3:0] l, input logic [1:0] md, input logic t);
    vec_t v;
    v.rst_n = r; v.en = e; v.mn = m; v.br = b; v.led = l; v.mode = md; v.tick = t;
    return v;
  endfunction

  initial begin
    exp_t te;
    // Reset, then RUN at full brightness: tick every 4 cycles, led one cycle later
    tbl[0]  = mk(0, 1, 0, 4'hF, 4'b0000, 0, 0);
    tbl[1]  = mk(0, 1, 0, 4'hF, 4'b0000, 0, 0);
    tbl[2]  = mk(1, 1, 0, 4'hF, 4'b0001, 0, 0);
    tbl[3]  = mk(1, 1, 0, 4'hF, 4'b0001, 0, 0);
    tbl[4]  = mk(1, 1, 0, 4'hF, 4'b0001, 0, 0);
    tbl[5]  = mk(1, 1, 0, 4'hF, 4'b0001, 0, 1);
    tbl[6]  = mk(1, 1, 0, 4'hF, 4'b0010, 0, 0);
    tbl[7]  = mk(1, 1, 0, 4'hF, 4'b0010, 0, 0);
    tbl[8]  = mk(1, 1, 0, 4'hF, 4'b0010, 0, 0);
    tbl[9]  = mk(1, 1, 0, 4'hF, 4'b0010, 0, 1);
    tbl[10] = mk(1, 1, 0, 4'hF, 4'b0100, 0, 0);

    rst_n = 0; enable = 1; mode_next = 0; brightness = 4'hF;
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      te.led = tbl[i].led; te.mode = tbl[i].mode; te.tick = tbl[i].tick;
      apply(tbl[i].rst_n, tbl[i].en, tbl[i].mn, tbl[i].br, 1'b1, te);
    end

    run(12, 1, 4'hF);                     // RUN through the 1000 -> 0001 wrap
    step(1, 1, 1, 4'hF); run(14, 1, 4'hF); // BLINK
    step(1, 1, 1, 4'hF); run(68, 1, 4'hF); // COUNT, wraps past 1111
    step(1, 1, 1, 4'hF); run(34, 1, 4'hF); // BOUNCE
    step(1, 1, 1, 4'hF); run(6, 1, 4'hF);  // back to RUN

    // mode_next coincident with the prescaler wrap
    for (int i = 0; i < 8 && m_presc != TC - 1; i++) step(1, 1, 0, 4'hF);
    if (m_presc != TC - 1) sync_fail("presc_last");
    step(1, 1, 1, 4'hF);
    run(10, 1, 4'hF);

    // PWM duty 4/16, then off, then a mid-stream change
    run(32, 1, 4'h4);
    run(16, 1, 4'h0);
    run(8, 1, 4'h9);

    // enable low mid-count, then resume; mode_next while disabled
    run(2, 1, 4'hF);
    run(10, 0, 4'hF);
    run(12, 1, 4'hF);
    step(1, 0, 0, 4'hF); step(1, 0, 1, 4'hF); run(4, 0, 4'hF);
    run(8, 1, 4'hF);

    // mode_next held for three cycles advances three modes
    step(1, 1, 1, 4'hF); step(1, 1, 1, 4'hF); step(1, 1, 1, 4'hF);
    run(6, 1, 4'hF);

    // BOUNCE moving right at 0100, then reset
    for (int i = 0; i < 8 && m_mode != 2'd3; i++) step(1, 1, 1, 4'hF);
    if (m_mode != 2'd3) sync_fail("mode3");
    for (int i = 0; i < 64 && m_idx != 4; i++) step(1, 1, 0, 4'hF);
    if (m_idx != 4) sync_fail("bounce_right");
    step(1, 1, 0, 4'hF);
    step(0, 1, 0, 4'hF);
    run(10, 1, 4'hF);

    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expectations left in queue", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
